// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared types and constants for the nibble-serial 74181 ALU:
//                FSM state encoding, common function selects and mode values.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // Controller states; explicit 2-bit encoding
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Frequently used 74181 function selects (active-high data)
    localparam logic [3:0] S_PASS_A = 4'b0000;
    localparam logic [3:0] S_SUB_M1 = 4'b0110;
    localparam logic [3:0] S_ADD    = 4'b1001;
    localparam logic [3:0] S_ONES   = 4'b1100;

    // Mode select
    localparam logic M_LOGIC = 1'b1;
    localparam logic M_ARITH = 1'b0;

endpackage
`default_nettype wire

// File: rtl/alu_nibble.sv
`default_nettype none
// ============================================================================
//  Module      : alu_nibble
//  Description : Combinational 4-bit 74181 slice, active-high data, active-low
//                carry in/out. Sole owner of the function table.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_nibble (
    input  logic [3:0] s,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       m,
    input  logic       cn,
    output logic [3:0] f,
    output logic       cn4
);

    // The 74181 reduces every function to two per-bit terms: arithmetic adds
    // them (plus carry), logic mode takes the inverted XOR of them.
    logic [3:0] w_x;
    logic [3:0] w_y;
    logic [4:0] w_sum;

    // Operand term generation, arithmetic sum and mode mux
    always_comb begin
        w_x   = a | (b & {4{s[0]}}) | (~b & {4{s[1]}});
        w_y   = (a & ~b & {4{s[2]}}) | (a & b & {4{s[3]}});
        w_sum = {1'b0, w_x} + {1'b0, w_y} + {4'b0000, ~cn};
        if (m) begin
            f   = ~(w_x ^ w_y);
            cn4 = 1'b1;
        end else begin
            f   = w_sum[3:0];
            cn4 = ~w_sum[4];
        end
    end

endmodule
`default_nettype wire

// File: rtl/serial_alu.sv
`default_nettype none
// ============================================================================
//  Module      : serial_alu
//  Description : WIDTH-bit 74181-style ALU evaluated one nibble per cycle,
//                LSB first, through a single slice. Valid/ready on both sides,
//                registered result and flags. WIDTH must be a multiple of 4.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       s,
    input  logic             m,
    input  logic             cn,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] f,
    output logic             cn4,
    output logic             aeqb,
    output logic             zero
);

    localparam int NIB   = WIDTH / 4;
    // Keep the index at least one bit wide so WIDTH=4 still elaborates
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(NIB - 1);

    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [3:0]         r_s;
    logic               r_m;
    logic               r_carry;
    logic [IDX_W-1:0]   r_idx;
    logic               w_last;
    logic [WIDTH-1:0]   w_a_sh;
    logic [WIDTH-1:0]   w_b_sh;
    logic [3:0]         w_slice_f;
    logic               w_slice_cn4;
    logic [WIDTH-1:0]   w_f_next;

    // Current nibble of each latched operand, selected by the nibble index
    always_comb begin
        w_a_sh = r_a >> {r_idx, 2'b00};
        w_b_sh = r_b >> {r_idx, 2'b00};
        w_last = (r_idx == C_LAST_IDX);
    end

    alu_nibble u_slice (
        .s   (r_s),
        .a   (w_a_sh[3:0]),
        .b   (w_b_sh[3:0]),
        .m   (r_m),
        .cn  (r_carry),
        .f   (w_slice_f),
        .cn4 (w_slice_cn4)
    );

    // Result with the current nibble merged in at the index position
    generate
        for (genvar gi = 0; gi < NIB; gi++) begin : g_nib
            assign w_f_next[4*gi +: 4] = (r_idx == IDX_W'(gi)) ? w_slice_f
                                                                : f[4*gi +: 4];
        end
    endgenerate

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode and handshake outputs
    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_next = BUSY;
                end
            end
            BUSY: begin
                if (w_last) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Operand capture, nibble sequencing, carry ripple, result and flags
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_s     <= S_PASS_A;
            r_m     <= M_ARITH;
            r_carry <= 1'b1;
            r_idx   <= '0;
            f       <= '0;
            cn4     <= 1'b1;
            aeqb    <= 1'b0;
            zero    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_s     <= s;
                        r_m     <= m;
                        r_carry <= cn;
                        r_idx   <= '0;
                    end
                end
                BUSY: begin
                    f       <= w_f_next;
                    r_carry <= w_slice_cn4;
                    r_idx   <= r_idx + IDX_W'(1);
                    // Flags come from the complete result, so latch them with
                    // the last nibble
                    if (w_last) begin
                        cn4  <= (r_m == M_LOGIC) ? 1'b1 : w_slice_cn4;
                        aeqb <= &w_f_next;
                        zero <= ~|w_f_next;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_alu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_alu
//  Description : Directed self-checking bench for serial_alu at WIDTH=16.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_alu;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  s;
    logic        m;
    logic        cn;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] f;
    logic        cn4;
    logic        aeqb;
    logic        zero;

    int n_cmp = 0;
    int n_err = 0;

    serial_alu #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .s         (s),
        .m         (m),
        .cn        (cn),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .f         (f),
        .cn4       (cn4),
        .aeqb      (aeqb),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Absolute run-time bound
    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Accept one bundle, scramble inputs afterwards, wait for the result and
    // check latency, result and flags. Leaves the DUT in DONE.
    task automatic do_op(input string tag, input logic [3:0] ts, input logic tm,
                         input logic tcn, input logic [15:0] ta, input logic [15:0] tb_,
                         input logic [15:0] ef, input logic ecn4, input logic eaeqb,
                         input logic ezero);
        int lat;
        chk({tag, ".in_ready"}, in_ready, 1);
        s = ts; m = tm; cn = tcn; a = ta; b = tb_;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        s = ~ts; m = ~tm; cn = ~tcn; a = ~ta; b = ~tb_;
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk({tag, ".latency"}, lat, 4);
        chk({tag, ".f"},       f,    ef);
        chk({tag, ".cn4"},     cn4,  ecn4);
        chk({tag, ".aeqb"},    aeqb, eaeqb);
        chk({tag, ".zero"},    zero, ezero);
        chk({tag, ".busy_ready"}, in_ready, 0);
    endtask

    task automatic drain(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, ".drain_valid"}, out_valid, 0);
        chk({tag, ".drain_ready"}, in_ready, 1);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        s = 4'h0; m = 1'b0; cn = 1'b1; a = 16'h0; b = 16'h0;
        tick();
        tick();
        chk("rst.out_valid", out_valid, 0);
        chk("rst.in_ready",  in_ready, 1);
        chk("rst.f",         f, 16'h0000);
        chk("rst.cn4",       cn4, 1);
        chk("rst.aeqb",      aeqb, 0);
        chk("rst.zero",      zero, 0);
        rst_n = 1'b1;
        tick();

        // Pass A
        do_op("pass_a", 4'b0000, 1'b0, 1'b1, 16'h1234, 16'h0001, 16'h1234, 1'b1, 1'b0, 1'b0);
        drain("pass_a");

        // Full-width carry ripple
        do_op("add_wrap", 4'b1001, 1'b0, 1'b1, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 1'b0, 1'b1);
        drain("add_wrap");

        // Carry out of the MSB nibble only, with carry-in
        do_op("add_msb", 4'b1001, 1'b0, 1'b0, 16'h8000, 16'h8000, 16'h0001, 1'b0, 1'b0, 1'b0);
        drain("add_msb");

        // A minus B minus 1: equality compare and ordinary differences
        do_op("cmp_eq", 4'b0110, 1'b0, 1'b1, 16'h5A5A, 16'h5A5A, 16'hFFFF, 1'b1, 1'b1, 1'b0);
        drain("cmp_eq");
        do_op("sub_m1", 4'b0110, 1'b0, 1'b1, 16'h0003, 16'h0005, 16'hFFFD, 1'b1, 1'b0, 1'b0);
        drain("sub_m1");
        do_op("sub_cin", 4'b0110, 1'b0, 1'b0, 16'h0003, 16'h0005, 16'hFFFE, 1'b1, 1'b0, 1'b0);
        drain("sub_cin");

        // Logic XOR, carry-in ignored and cn4 forced high
        do_op("xor", 4'b0110, 1'b1, 1'b0, 16'hF0F0, 16'hFF00, 16'h0FF0, 1'b1, 1'b0, 1'b0);
        drain("xor");

        // Backpressure: result held, concurrent bundle refused
        do_op("bp", 4'b1001, 1'b0, 1'b1, 16'h00FF, 16'h0001, 16'h0100, 1'b1, 1'b0, 1'b0);
        s = 4'b1100; m = 1'b1; a = 16'hAAAA; b = 16'h5555;
        in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("bp.hold_valid", out_valid, 1);
            chk("bp.hold_ready", in_ready, 0);
            chk("bp.hold_f",     f, 16'h0100);
            chk("bp.hold_flags", {cn4, aeqb, zero}, 3'b100);
        end
        in_valid = 1'b0;
        drain("bp");

        // Reset in the middle of BUSY
        s = 4'b1001; m = 1'b0; cn = 1'b1; a = 16'h1111; b = 16'h2222;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        chk("midrst.out_valid", out_valid, 0);
        chk("midrst.f",         f, 16'h0000);
        chk("midrst.cn4",       cn4, 1);
        chk("midrst.in_ready",  in_ready, 1);
        rst_n = 1'b1;
        do_op("post_rst", 4'b1001, 1'b0, 1'b1, 16'h1111, 16'h2222, 16'h3333, 1'b1, 1'b0, 1'b0);
        drain("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
